// File: rtl/mux_4_to_1_arbiter_if.sv
// mux_4_to_1_arbiter_if: request/data bundle and registered grant/select/data outputs
interface mux_4_to_1_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   out;
    logic               valid;
    modport master (output req, din, input gnt, sel, out, valid);
    modport slave  (input req, din, output gnt, sel, out, valid);
endinterface

// File: rtl/mux_4_to_1_arbiter.sv
// mux_4_to_1_arbiter: round-robin owner of a shared 4:1 mux with hold limit and registered data
module mux_4_to_1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input logic                 clk,
    input logic                 rst,
    mux_4_to_1_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [1:0]    ptr, win, idx;
    logic [HW-1:0] hcnt;
    logic [3:0]    cur, arb_req;
    logic          natural, forced, found, take, dv;
    always_comb begin
        cur     = 4'b1 << bus.sel;
        dv      = (state == GRANT) && bus.req[bus.sel];
        natural = (state == GRANT) && !bus.req[bus.sel];
        forced  = dv && hcnt == HW'(MAX_HOLD) && (bus.req & ~cur) != 4'b0;
        arb_req = forced ? bus.req & ~cur : bus.req;
        take    = state == IDLE || natural || forced;
        win     = 2'b0;
        found   = 1'b0;
        idx     = 2'b0;
        // first requester at or after ptr, wrapping modulo 4
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && arb_req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'b0;
            hcnt      <= '0;
            bus.gnt   <= 4'b0;
            bus.sel   <= 2'b0;
            bus.out   <= '0;
            bus.valid <= 1'b0;
        end else begin
            bus.valid <= dv;
            if (dv) bus.out <= bus.din[32'(bus.sel) * WIDTH +: WIDTH];
            if (take && found) begin
                state   <= GRANT;
                bus.gnt <= 4'b1 << win;
                bus.sel <= win;
                ptr     <= win + 2'd1;
                hcnt    <= HW'(1);
            end else if (take) begin
                state   <= IDLE;
                bus.gnt <= 4'b0;
            end else if (hcnt != HW'(MAX_HOLD)) begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end
endmodule
